// File: rtl/c1_responder_if.sv
// C1 bus between a CPU (master) and the c1_responder byte store (slave).
// Signal names carry the responder's view: i_* flow into it, o_* flow out of it.
interface c1_responder_if #(
  parameter int ADDR1_W = 15
);
  logic [ADDR1_W-1:0] i_a1;
  logic [15:0]        i_d1;
  logic [2:0]         i_c1;
  logic [15:0]        o_d1;
  logic               o_d1_oe;
  logic [2:0]         o_c1;
  logic               o_c1_oe;

  modport master (output i_a1, i_d1, i_c1, input  o_d1, o_d1_oe, o_c1, o_c1_oe);
  modport slave  (input  i_a1, i_d1, i_c1, output o_d1, o_d1_oe, o_c1, o_c1_oe);
endinterface

// File: rtl/c1_responder.sv
// Two-beat command responder backed by a small byte-addressed store.
// Beat 1 carries command, tag/set address and data word 1; beat 2 carries the
// offset and data word 2. After LATENCY cycles it answers with one RESPONSE
// cycle (two for READ32). All outputs are registered.
module c1_responder #(
  parameter int ADDR1_W  = 15,
  parameter int OFFSET_W = 4,
  parameter int MEM_AW   = 10,
  parameter int LATENCY  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  c1_responder_if.slave  c1
);
  typedef enum logic [2:0] {S_IDLE, S_BEAT2, S_WAIT, S_RESP1, S_RESP2} state_t;

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_READ8  = 3'd1;
  localparam logic [2:0] CMD_READ32 = 3'd3;
  localparam logic [2:0] CMD_WRITE8 = 3'd5;
  localparam logic [2:0] CMD_WRITE32 = 3'd7;
  localparam logic [2:0] C1_RESP    = 3'd7;
  // WAIT spans LATENCY-1 cycles; the counter holds the remaining extra cycles.
  localparam int         CNT_INIT_I = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [2:0]         r_cmd;
  logic [ADDR1_W-1:0] r_addr_hi;
  logic [OFFSET_W-1:0] r_off;
  logic [15:0]        r_beat1, r_beat2;
  logic [15:0]        r_rd_hi;
  logic [15:0]        r_d1_out;
  logic               r_d1_oe;
  logic [2:0]         r_c1_out;
  logic               r_c1_oe;
  logic [7:0]         r_mem [2**MEM_AW];

  logic [OFFSET_W-1:0] w_off;
  logic [15:0]         w_beat2;
  logic [MEM_AW-1:0]   w_a0, w_a1, w_a2, w_a3;
  logic [7:0]          w_rb0, w_rb1, w_rb2, w_rb3;
  logic                w_enter_resp, w_is_read, w_is_write;

  // With LATENCY=1 the response is entered on the beat-2 edge itself, so the
  // offset and beat-2 data must bypass their registers in that state.
  assign w_off   = (r_state == S_BEAT2) ? c1.i_a1[OFFSET_W-1:0] : r_off;
  assign w_beat2 = (r_state == S_BEAT2) ? c1.i_d1 : r_beat2;
  assign w_a0    = MEM_AW'({r_addr_hi, w_off});
  assign w_a1    = w_a0 + MEM_AW'(1);
  assign w_a2    = w_a0 + MEM_AW'(2);
  assign w_a3    = w_a0 + MEM_AW'(3);
  assign w_rb0   = r_mem[w_a0];
  assign w_rb1   = r_mem[w_a1];
  assign w_rb2   = r_mem[w_a2];
  assign w_rb3   = r_mem[w_a3];

  assign w_is_read    = (r_cmd >= CMD_READ8)  && (r_cmd <= CMD_READ32);
  assign w_is_write   = (r_cmd >= CMD_WRITE8);
  assign w_enter_resp = ((r_state == S_BEAT2) && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign c1.o_d1    = r_d1_out;
  assign c1.o_d1_oe = r_d1_oe;
  assign c1.o_c1    = r_c1_out;
  assign c1.o_c1_oe = r_c1_oe;

  // Store update on the edge that enters RESP1; reset aborts it and never clears the store.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_enter_resp && w_is_write) begin
      r_mem[w_a0] <= r_beat1[7:0];
      if (r_cmd != CMD_WRITE8) r_mem[w_a1] <= r_beat1[15:8];
      if (r_cmd == CMD_WRITE32) begin
        r_mem[w_a2] <= w_beat2[7:0];
        r_mem[w_a3] <= w_beat2[15:8];
      end
    end
  end

  // Command FSM with registered bus outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_cmd     <= CMD_NOP;
      r_addr_hi <= '0;
      r_off     <= '0;
      r_beat1   <= 16'd0;
      r_beat2   <= 16'd0;
      r_rd_hi   <= 16'd0;
      r_d1_out  <= 16'd0;
      r_d1_oe   <= 1'b0;
      r_c1_out  <= CMD_NOP;
      r_c1_oe   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (c1.i_c1 != CMD_NOP) begin
          r_cmd     <= c1.i_c1;
          r_addr_hi <= c1.i_a1;
          r_beat1   <= c1.i_d1;
          r_state   <= S_BEAT2;
        end
        S_BEAT2: begin
          r_off    <= c1.i_a1[OFFSET_W-1:0];
          r_beat2  <= c1.i_d1;
          r_cnt    <= CNT_INIT;
          r_c1_oe  <= 1'b1;
          r_c1_out <= CMD_NOP;
          r_state  <= S_WAIT;
        end
        S_WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        S_RESP1: if (r_cmd == CMD_READ32) begin
          r_d1_out <= r_rd_hi;
          r_state  <= S_RESP2;
        end else begin
          r_c1_oe  <= 1'b0;
          r_c1_out <= CMD_NOP;
          r_d1_oe  <= 1'b0;
          r_d1_out <= 16'd0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_c1_oe  <= 1'b0;
          r_c1_out <= CMD_NOP;
          r_d1_oe  <= 1'b0;
          r_d1_out <= 16'd0;
          r_state  <= S_IDLE;
        end
      endcase
      // Entering RESP1 overrides the BEAT2/WAIT assignments above; read data
      // is sampled here, bytes 2/3 are parked for a READ32 second cycle.
      if (w_enter_resp) begin
        r_state  <= S_RESP1;
        r_c1_oe  <= 1'b1;
        r_c1_out <= C1_RESP;
        r_d1_oe  <= w_is_read;
        r_d1_out <= !w_is_read ? 16'd0 :
                    (r_cmd == CMD_READ8) ? {8'd0, w_rb0} : {w_rb1, w_rb0};
        r_rd_hi  <= {w_rb3, w_rb2};
      end
    end
  end
endmodule

// File: tb/tb_c1_responder.sv
// Directed bench: a LATENCY=4 and a LATENCY=1 responder share clock and reset.
module tb_c1_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c1_responder_if #(.ADDR1_W(15)) bus4();
  c1_responder_if #(.ADDR1_W(15)) bus1();
  c1_responder #(.ADDR1_W(15), .OFFSET_W(4), .MEM_AW(10), .LATENCY(4))
    dut4 (.i_clk(clk), .i_rst(rst), .c1(bus4));
  c1_responder #(.ADDR1_W(15), .OFFSET_W(4), .MEM_AW(10), .LATENCY(1))
    dut1 (.i_clk(clk), .i_rst(rst), .c1(bus1));

  typedef struct {
    bit          sel;   // 1 = LATENCY=1 instance
    logic [2:0]  cmd;
    logic [15:0] addr, d1, d2, e0, e1;
  } vec_t;

  int errs = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit sel, logic [2:0] c, logic [14:0] a, logic [15:0] d);
    bus4.i_c1 = sel ? 3'd0 : c;  bus4.i_a1 = a;  bus4.i_d1 = d;
    bus1.i_c1 = sel ? c : 3'd0;  bus1.i_a1 = a;  bus1.i_d1 = d;
  endtask

  task automatic samp(bit sel, output logic oe, output logic [2:0] co,
                      output logic doe, output logic [15:0] d);
    oe  = sel ? bus1.o_c1_oe : bus4.o_c1_oe;
    co  = sel ? bus1.o_c1    : bus4.o_c1;
    doe = sel ? bus1.o_d1_oe : bus4.o_d1_oe;
    d   = sel ? bus1.o_d1    : bus4.o_d1;
  endtask

  // Issues one command starting at the current negedge and checks the whole
  // response; returns at the negedge where the responder is idle again.
  task automatic do_cmd(string nm, vec_t v);
    logic oe, doe; logic [2:0] co; logic [15:0] d;
    int lat, L;
    bit got, rd;
    L   = v.sel ? 1 : 4;
    rd  = (v.cmd >= 3'd1) && (v.cmd <= 3'd3);
    lat = 0;
    got = 1'b0;
    drive(v.sel, v.cmd, 15'(v.addr >> 4), v.d1);
    @(negedge clk);
    samp(v.sel, oe, co, doe, d);
    chk({nm, ":beat2_c1oe"}, 32'(oe), 32'd0);
    drive(v.sel, 3'd0, 15'(v.addr & 16'h000F), v.d2);
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      samp(v.sel, oe, co, doe, d);
      if (oe && co == 3'd7) begin
        got = 1'b1;
        lat = k;
        drive(v.sel, 3'd0, 15'd0, 16'd0);
      end else begin
        if (k < L) begin
          chk({nm, ":wait_c1oe"}, 32'(oe), 32'd1);
          chk({nm, ":wait_d1oe"}, 32'(doe), 32'd0);
        end
        // a stray command during WAIT must be ignored
        if (!v.sel) drive(0, 3'd5, 15'h7FFF, 16'hDEAD);
      end
    end
    chk({nm, ":latency"}, 32'(lat), 32'(L));
    if (!got) begin
      drive(v.sel, 3'd0, 15'd0, 16'd0);
      return;
    end
    chk({nm, ":resp1_d1oe"}, 32'(doe), 32'(rd));
    chk({nm, ":resp1_d1"}, 32'(d), 32'(v.e0));
    @(negedge clk);
    samp(v.sel, oe, co, doe, d);
    if (v.cmd == 3'd3) begin
      chk({nm, ":resp2_c1"}, {oe, co}, {1'b1, 3'd7});
      chk({nm, ":resp2_d1"}, 32'(d), 32'(v.e1));
      @(negedge clk);
      samp(v.sel, oe, co, doe, d);
    end
    chk({nm, ":end_c1oe"}, 32'(oe), 32'd0);
    chk({nm, ":end_d1"}, {15'd0, doe, d}, 32'd0);
  endtask

  task automatic chk_zero(string nm);
    logic oe, doe; logic [2:0] co; logic [15:0] d;
    for (int s = 0; s < 2; s++) begin
      samp(s[0], oe, co, doe, d);
      chk($sformatf("%s_dut%0d", nm, s), {oe, co, doe, d}, 32'd0);
    end
  endtask

  vec_t v[16];

  initial begin
    // WRITE8=5 WRITE16=6 WRITE32=7 READ8=1 READ16=2 READ32=3 INV=4
    v[0]  = '{0, 3'd5, 16'h000F, 16'h0077, 16'h0000, 16'h0000, 16'h0000};
    v[1]  = '{0, 3'd5, 16'h0020, 16'h9911, 16'h0000, 16'h0000, 16'h0000};
    v[2]  = '{0, 3'd7, 16'h0103, 16'hC87C, 16'h0525, 16'h0000, 16'h0000};
    v[3]  = '{0, 3'd3, 16'h0103, 16'h0000, 16'h0000, 16'hC87C, 16'h0525};
    v[4]  = '{0, 3'd5, 16'h0010, 16'h00AB, 16'h0000, 16'h0000, 16'h0000};
    v[5]  = '{0, 3'd2, 16'h000F, 16'h0000, 16'h0000, 16'hAB77, 16'h0000};
    v[6]  = '{0, 3'd6, 16'h03FF, 16'h2211, 16'h0000, 16'h0000, 16'h0000};
    v[7]  = '{0, 3'd1, 16'h03FF, 16'h0000, 16'h0000, 16'h0011, 16'h0000};
    v[8]  = '{0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0022, 16'h0000};
    v[9]  = '{0, 3'd4, 16'h0103, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    v[10] = '{0, 3'd3, 16'h0103, 16'h0000, 16'h0000, 16'hC87C, 16'h0525};
    v[11] = '{0, 3'd1, 16'h0103, 16'h0000, 16'h0000, 16'h007C, 16'h0000};
    v[12] = '{1, 3'd7, 16'h0040, 16'hBEEF, 16'h1234, 16'h0000, 16'h0000};
    v[13] = '{1, 3'd1, 16'h0040, 16'h0000, 16'h0000, 16'h00EF, 16'h0000};
    v[14] = '{1, 3'd1, 16'h0041, 16'h0000, 16'h0000, 16'h00BE, 16'h0000};
    v[15] = '{1, 3'd3, 16'h0040, 16'h0000, 16'h0000, 16'hBEEF, 16'h1234};

    drive(0, 3'd0, 15'd0, 16'd0);
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b0;
    // first command lands on the first edge with reset low
    for (int i = 0; i < 16; i++) do_cmd($sformatf("vec%0d", i), v[i]);

    // reset during WAIT of WRITE8 0x0020 aborts the write
    begin
      logic oe, doe; logic [2:0] co; logic [15:0] d;
      drive(0, 3'd5, 15'h0002, 16'h0055);
      @(negedge clk);
      drive(0, 3'd0, 15'h0000, 16'h0000);
      @(negedge clk);
      samp(0, oe, co, doe, d);
      chk("rstwait_c1oe", 32'(oe), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("rstwait_outputs");
      rst = 1'b0;
      do_cmd("after_reset_read", '{0, 3'd1, 16'h0020, 16'h0000, 16'h0000, 16'h0011, 16'h0000});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
